// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and response-slot state encoding.
package alu_arbiter_pkg;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_LE  = 4'b0111;
    localparam logic [3:0] CTL_SLL = 4'b1000;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int DWIDTH = 32
);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DWIDTH-1:0] req_a0;
    logic [DWIDTH-1:0] req_b0;
    logic [DWIDTH-1:0] req_a1;
    logic [DWIDTH-1:0] req_b1;
    logic [3:0]        req_ctl0;
    logic [3:0]        req_ctl1;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DWIDTH-1:0] resp_out0;
    logic [DWIDTH-1:0] resp_out1;
    logic              resp_zero0;
    logic              resp_zero1;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_ctl0, req_ctl1, resp_ready,
        input  req_ready, resp_valid, resp_out0, resp_out1, resp_zero0, resp_zero1
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_ctl0, req_ctl1, resp_ready,
        output req_ready, resp_valid, resp_out0, resp_out1, resp_zero0, resp_zero1
    );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational ALU shared by both requesters; unknown control codes give 0.
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [3:0]        ctl,
    output logic [DWIDTH-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (ctl)
            CTL_AND: result = a & b;
            CTL_OR:  result = a | b;
            CTL_ADD: result = a + b;
            CTL_SUB: result = a - b;
            CTL_LE:  result = DWIDTH'(a < b);
            CTL_SLL: result = a << b[4:0];
            CTL_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU, with a one-entry response slot per port.
// Define ALU_ARB_RR_EN for round-robin tie-break; otherwise port 0 wins every tie.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              port0_wins;
    slot_state_t       slot_q [2];
    logic [DWIDTH-1:0] out_q  [2];
    logic [1:0]        zero_q;
    logic [DWIDTH-1:0] alu_a;
    logic [DWIDTH-1:0] alu_b;
    logic [3:0]        alu_ctl;
    logic [DWIDTH-1:0] alu_result;
    logic              alu_zero;

    // A port may issue when its slot is free or is being drained this same cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = bus.req_valid[i] & ((slot_q[i] == SLOT_EMPTY) | bus.resp_ready[i]);
        end
    end

`ifdef ALU_ARB_RR_EN
    logic last_grant_q;

    assign port0_wins = last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (grant[0]) begin
            last_grant_q <= 1'b0;
        end else if (grant[1]) begin
            last_grant_q <= 1'b1;
        end
    end
`else
    assign port0_wins = 1'b1;
`endif

    always_comb begin
        grant = '0;
        if (rst_n) begin
            grant[0] = eligible[0] & (~eligible[1] | port0_wins);
            grant[1] = eligible[1] & (~eligible[0] | ~port0_wins);
        end
    end

    assign alu_a   = grant[1] ? bus.req_a1   : bus.req_a0;
    assign alu_b   = grant[1] ? bus.req_b1   : bus.req_b0;
    assign alu_ctl = grant[1] ? bus.req_ctl1 : bus.req_ctl0;

    alu_core #(
        .DWIDTH (DWIDTH)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctl    (alu_ctl),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Slot FSMs: an accept always wins over a drain so a simultaneous pair keeps the slot full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                out_q[i]  <= '0;
                zero_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    slot_q[i] <= SLOT_FULL;
                    out_q[i]  <= alu_result;
                    zero_q[i] <= alu_zero;
                end else if (slot_q[i] == SLOT_FULL && bus.resp_ready[i]) begin
                    slot_q[i] <= SLOT_EMPTY;
                end
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.resp_valid = {slot_q[1] == SLOT_FULL, slot_q[0] == SLOT_FULL};
    assign bus.resp_out0  = out_q[0];
    assign bus.resp_out1  = out_q[1];
    assign bus.resp_zero0 = zero_q[0];
    assign bus.resp_zero1 = zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: ALU vector table, hand-written corner sequences, random run vs reference model.
// Honours ALU_ARB_RR_EN the same way the design does.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DWIDTH(DW)) bus ();

    alu_arbiter #(.DWIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [13];

    // Reference model: per-port pending result (or none) plus who went last.
    bit          m_full [2];
    logic [31:0] m_val  [2];
    bit          m_zero [2];
`ifdef ALU_ARB_RR_EN
    int          m_last;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rdy,
                                 input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
        bus.req_valid  = valid;
        bus.resp_ready = rdy;
        bus.req_ctl0   = c0;
        bus.req_a0     = a0;
        bus.req_b0     = b0;
        bus.req_ctl1   = c1;
        bus.req_a1     = a1;
        bus.req_b1     = b1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] rdy);
        applyStimulus(2'b00, rdy, CTL_AND, 32'd0, 32'd0, CTL_AND, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2'b00);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            CTL_AND: return a & b;
            CTL_OR:  return a | b;
            CTL_ADD: return a + b;
            CTL_SUB: return a - b;
            CTL_LE:  return (a < b) ? 32'd1 : 32'd0;
            CTL_SLL: return a << b[4:0];
            CTL_NOR: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0;
            m_val[i]  = 32'd0;
            m_zero[i] = 1'b0;
        end
`ifdef ALU_ARB_RR_EN
        m_last = 1;
`endif
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] valid, input logic [1:0] rdy);
        int cands [$];
        int winner;
        for (int i = 0; i < 2; i++) begin
            if (valid[i] && (!m_full[i] || rdy[i])) cands.push_back(i);
        end
        if (cands.size() == 0) return 2'b00;
        if (cands.size() == 1) winner = cands[0];
`ifdef ALU_ARB_RR_EN
        else winner = 1 - m_last;
`else
        else winner = 0;
`endif
        return (winner == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_commit(input logic [1:0] g, input logic [1:0] rdy,
                                input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                m_val[i]  = (i == 0) ? alu_ref(c0, a0, b0) : alu_ref(c1, a1, b1);
                m_zero[i] = (m_val[i] == 32'd0);
                m_full[i] = 1'b1;
`ifdef ALU_ARB_RR_EN
                m_last    = i;
`endif
            end else if (rdy[i]) begin
                m_full[i] = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] exp_grants [4];
        logic [1:0] v, r, eg;
        logic [3:0] c0, c1;
        logic [31:0] a0, b0, a1, b1;

        vecs[0]  = '{CTL_ADD, 32'd5,          32'd7,          32'd12,         1'b0};
        vecs[1]  = '{CTL_SUB, 32'd9,          32'd9,          32'd0,          1'b1};
        vecs[2]  = '{CTL_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
        vecs[3]  = '{CTL_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
        vecs[4]  = '{CTL_LE,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[5]  = '{CTL_LE,  32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0};
        vecs[6]  = '{CTL_SLL, 32'd1,          32'd4,          32'd16,         1'b0};
        vecs[7]  = '{CTL_SLL, 32'd3,          32'h0000_0024,  32'h0000_0030,  1'b0};
        vecs[8]  = '{CTL_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
        vecs[9]  = '{4'b1111, 32'd5,          32'd7,          32'd0,          1'b1};
        vecs[10] = '{CTL_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vecs[11] = '{CTL_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
        vecs[12] = '{4'b0011, 32'd1,          32'd1,          32'd0,          1'b1};

        // Reset with both requesters asking: nothing may be granted or captured.
        rst_n = 1'b0;
        applyStimulus(2'b11, 2'b11, CTL_ADD, 32'd1, 32'd2, CTL_ADD, 32'd3, 32'd4);
        checkOutput("reset req_ready", bus.req_ready, 2'b00);
        tick();
        tick();
        checkOutput("reset resp_valid", bus.resp_valid, 2'b00);
        checkOutput("reset resp_out0", bus.resp_out0, 32'd0);
        checkOutput("reset resp_out1", bus.resp_out1, 32'd0);
        checkOutput("reset zero", {bus.resp_zero1, bus.resp_zero0}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 alone: 5+7 appears one cycle after acceptance.
        applyStimulus(2'b01, 2'b01, CTL_ADD, 32'd5, 32'd7, CTL_AND, 32'd0, 32'd0);
        checkOutput("p0 add req_ready", bus.req_ready, 2'b01);
        tick();
        checkOutput("p0 add resp_valid", bus.resp_valid, 2'b01);
        checkOutput("p0 add resp_out0", bus.resp_out0, 32'd12);
        checkOutput("p0 add resp_zero0", bus.resp_zero0, 1'b0);
        idle(2'b11);
        tick();
        checkOutput("drain resp_valid", bus.resp_valid, 2'b00);

        // ALU function table through port 0 at one op per cycle.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(2'b01, 2'b01, vecs[i].ctl, vecs[i].a, vecs[i].b, CTL_AND, 32'd0, 32'd0);
            checkOutput($sformatf("vec%0d req_ready", i), bus.req_ready, 2'b01);
            tick();
            checkOutput($sformatf("vec%0d resp_out0", i), bus.resp_out0, vecs[i].exp_out);
            checkOutput($sformatf("vec%0d resp_zero0", i), bus.resp_zero0, vecs[i].exp_zero);
        end
        idle(2'b11);
        tick();

        // Tie from reset: alternating grants with round-robin, port 0 always otherwise.
        do_reset();
`ifdef ALU_ARB_RR_EN
        exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_grants = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 2'b11, CTL_SUB, 32'd9, 32'd9, CTL_SLL, 32'd1, 32'd4);
            checkOutput($sformatf("tie%0d req_ready", i), bus.req_ready, exp_grants[i]);
            tick();
        end
        checkOutput("tie resp_out0", bus.resp_out0, 32'd0);
        checkOutput("tie resp_zero0", bus.resp_zero0, 1'b1);
`ifdef ALU_ARB_RR_EN
        checkOutput("tie resp_out1", bus.resp_out1, 32'd16);
        checkOutput("tie resp_zero1", bus.resp_zero1, 1'b0);
`else
        checkOutput("tie resp_valid1", bus.resp_valid[1], 1'b0);
        checkOutput("tie resp_out1", bus.resp_out1, 32'd0);
`endif
        idle(2'b11);
        tick();

        // Port 1 slot full and not drained: new request stalls and old result holds.
        applyStimulus(2'b10, 2'b00, CTL_AND, 32'd0, 32'd0, CTL_ADD, 32'd1, 32'd2);
        checkOutput("p1 load req_ready", bus.req_ready, 2'b10);
        tick();
        checkOutput("p1 load resp_out1", bus.resp_out1, 32'd3);
        applyStimulus(2'b10, 2'b00, CTL_AND, 32'd0, 32'd0, CTL_OR, 32'hF0, 32'h0F);
        checkOutput("p1 stall req_ready", bus.req_ready, 2'b00);
        tick();
        checkOutput("p1 stall resp_out1", bus.resp_out1, 32'd3);
        checkOutput("p1 stall resp_valid", bus.resp_valid, 2'b10);
        applyStimulus(2'b10, 2'b10, CTL_AND, 32'd0, 32'd0, CTL_OR, 32'hF0, 32'h0F);
        checkOutput("p1 drain+accept req_ready", bus.req_ready, 2'b10);
        tick();
        checkOutput("p1 overwrite resp_out1", bus.resp_out1, 32'hFF);
        checkOutput("p1 overwrite resp_valid", bus.resp_valid, 2'b10);

        // Both slots full and nobody draining: no grant, nothing lost.
        applyStimulus(2'b01, 2'b00, CTL_ADD, 32'd5, 32'd7, CTL_AND, 32'd0, 32'd0);
        tick();
        applyStimulus(2'b11, 2'b00, CTL_ADD, 32'd100, 32'd1, CTL_ADD, 32'd200, 32'd1);
        checkOutput("both full req_ready", bus.req_ready, 2'b00);
        tick();
        checkOutput("both full resp_valid", bus.resp_valid, 2'b11);
        checkOutput("both full resp_out0", bus.resp_out0, 32'd12);
        checkOutput("both full resp_out1", bus.resp_out1, 32'hFF);

        // Reset right after an accept drops the result immediately.
        applyStimulus(2'b01, 2'b01, CTL_ADD, 32'd20, 32'd22, CTL_AND, 32'd0, 32'd0);
        tick();
        checkOutput("pre-reset resp_out0", bus.resp_out0, 32'd42);
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset resp_valid", bus.resp_valid, 2'b00);
        checkOutput("mid reset resp_out0", bus.resp_out0, 32'd0);
        checkOutput("mid reset resp_out1", bus.resp_out1, 32'd0);
        checkOutput("mid reset req_ready", bus.req_ready, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b11, 2'b11, CTL_ADD, 32'd1, 32'd1, CTL_ADD, 32'd2, 32'd2);
        checkOutput("post reset tie req_ready", bus.req_ready, 2'b01);
        tick();
        checkOutput("post reset resp_out0", bus.resp_out0, 32'd2);
        idle(2'b11);
        tick();

        // Back-to-back port 0 operations with no bubbles.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b01, 2'b01, CTL_ADD, 32'(i), 32'd100, CTL_AND, 32'd0, 32'd0);
            checkOutput($sformatf("b2b%0d req_ready", i), bus.req_ready, 2'b01);
            tick();
            checkOutput($sformatf("b2b%0d resp_out0", i), bus.resp_out0, 32'(i + 100));
            checkOutput($sformatf("b2b%0d resp_valid0", i), bus.resp_valid[0], 1'b1);
        end
        idle(2'b11);
        tick();

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            v  = 2'($urandom_range(0, 3));
            r  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            c0 = 4'($urandom_range(0, 15));
            c1 = 4'($urandom_range(0, 15));
            a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            applyStimulus(v, r, c0, a0, b0, c1, a1, b1);
            eg = model_grant(v, r);
            checkOutput($sformatf("rand%0d req_ready", n), bus.req_ready, eg);
            tick();
            model_commit(eg, r, c0, a0, b0, c1, a1, b1);
            checkOutput($sformatf("rand%0d resp_valid", n), bus.resp_valid, {m_full[1], m_full[0]});
            checkOutput($sformatf("rand%0d resp_out0", n), bus.resp_out0, m_val[0]);
            checkOutput($sformatf("rand%0d resp_out1", n), bus.resp_out1, m_val[1]);
            checkOutput($sformatf("rand%0d zero", n), {bus.resp_zero1, bus.resp_zero0}, {m_zero[1], m_zero[0]});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares one combinational ALU instance between a primary requester (port 0, pipeline execute stage) and a secondary requester (port 1, e.g. address-generation or debug unit). Each requester issues operations over a valid/ready handshake. The arbiter grants at most one operation per cycle and registers the ALU result into a per-requester one-entry response slot. Each slot is drained over its own valid/ready handshake.

## Interface
- `DWIDTH`, default 32: operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid[1:0]`  in  2  per-requester operation valid.
- `req_ready[1:0]`  out  2  per-requester accept; a transfer occurs when valid and ready are both high.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  DWIDTH each  operands for requesters 0 and 1.
- `req_ctl0`, `req_ctl1`  in  4 each  ALU control code.
- `resp_valid[1:0]`  out  2  response slot holds a result.
- `resp_ready[1:0]`  in  2  requester consumes its response.
- `resp_out0`, `resp_out1`  out  DWIDTH each  registered ALU result.
- `resp_zero0`, `resp_zero1`  out  1 each  registered zero flag, equal to (result == 0).

## Operation
- Control codes: AND=0000, OR=0001, ADD=0010, SUB=0110, LE=0111 (unsigned A<B gives 1, else 0), SLL=1000 (shift amount B[4:0]), NOR=1100.
  - Any other code yields result 0 and zero=1.
  - Codes are passed through unchecked.
- Eligibility of requester i: `req_valid[i]` AND (slot i empty OR `resp_ready[i]` high this cycle).
- Grant selects one eligible requester per cycle.
  - Only one eligible: it is granted.
  - Both eligible: priority goes to the requester not granted most recently (round-robin, see Configuration).
- `req_ready[i]` = grant[i]. It is combinational from the `req_valid` and `resp_ready` of both ports, and no other port.
- The ALU operand and ctl mux is driven from the granted port. With no grant, the mux selects port 0 and the result is discarded.
- On an accepted transfer for port i, at the clock edge:
  - `resp_out_i`/`resp_zero_i` are loaded.
  - `resp_valid[i]` is set.
  - The `last_grant` register is updated to i.
- Slot i FSM:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `resp_ready[i]` with no accept.
  - FULL→FULL on simultaneous drain and accept (new result overwrites, valid stays 1).
- A non-granted port's slot and outputs are unchanged.
- `resp_out`/`resp_zero` hold their value while the slot is FULL and `resp_ready` is low.

## Timing
- Latency: accept at edge N gives `resp_valid` high from after edge N. One operation per cycle aggregate.
- Single-requester throughput: 1 op/cycle while `resp_ready` is held high.
- Reset (asynchronous assert, synchronous-release usage):
  - `resp_valid`=00, `resp_out*`=0, `resp_zero*`=0.
  - `last_grant`=1, so port 0 wins the first tie.
  - `req_ready`=00 while `rst_n` is low.
- Reset mid-operation: in-flight results are dropped and no response is produced for them.
- Both slots FULL with no `resp_ready`: `req_ready`=00, with no loss of stored results.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin tie-break using `last_grant` as above.
- `ALU_ARB_RR_EN` undefined: fixed priority; port 0 always wins a tie and the `last_grant` register is not built.

## Structure
- Shared package/header holds the 4-bit ALU control codes and the slot state encoding (EMPTY=0, FULL=1).
- One sub-module, `alu_core`: a purely combinational ALU (A, B, ctl → out, zero) using the codes above.
- The arbiter holds all state: two slot FSMs, the result registers, and `last_grant`.

## Test plan
- Port 0 only, ADD a=5 b=7, `resp_ready0`=1 → `req_ready0`=1; next cycle `resp_out0`=12, `resp_zero0`=0.
- Both valid every cycle, port 0 SUB 9-9, port 1 SLL 1<<4, both `resp_ready`=1, from reset → grants alternate 0,1,0,1. `resp_out0`=0 with zero=1; `resp_out1`=16. With RR disabled → port 0 granted every cycle and `req_ready1` stays 0.
- Port 1 slot FULL with `resp_ready1`=0, port 1 requests OR 0xF0|0x0F → `req_ready1`=0 and `resp_out1` holds the old value. Raise `resp_ready1` → accept the same cycle, next cycle `resp_out1`=0xFF.
- LE unsigned: a=0xFFFFFFFF, b=1 → `resp_out`=0. Illegal ctl 4'b1111 → `resp_out`=0, zero=1.
- Assert `rst_n`=0 in the cycle after an accept, before drain → `resp_valid`=00 and outputs 0 immediately. After release, port 0 wins the first tie.
- Back-to-back port 0 ADDs with `resp_ready0` held 1 for 8 cycles → 8 results in order, one per cycle, no bubbles.
